dma_loop_gen: RTL and testbench
===============================

# dma_loop_gen

Packet generator that sources the AXI-Stream MM2S input of the DMA loopback FIFO. On a start pulse it emits a programmed number of packets of a programmed byte length, with a deterministic incrementing data pattern, correct `tkeep` on the final beat of each packet, and `tlast` framing. It gives loopback tests a known stimulus source that a downstream checker can predict exactly.

## Interface
- `AXI_DATA_WIDTH`, 64, stream data width in bits; `BE_WIDTH = AXI_DATA_WIDTH/8` (local).
- `axi_clk`  in  1  single clock; all logic is on the rising edge.
- `axi_rst_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle pulse; begins a run when the FSM is IDLE.
- `abort`  in  1  level; stops the run after the current packet finishes.
- `pkt_len`  in  16  packet length in bytes; sampled at the accepted `start`.
- `pkt_count`  in  16  number of packets in the run; sampled at the accepted `start`.
- `seed`  in  AXI_DATA_WIDTH  value of the first beat's data; sampled at the accepted `start`.
- `busy`  out  1  high from the cycle after an accepted start until the DONE cycle, inclusive.
- `done`  out  1  one-cycle pulse marking the end of a run.
- `tx_beats`  out  32  number of beats accepted in the current or last run.
- `m_axis_mm2s_tdata`  out  AXI_DATA_WIDTH  stream data.
- `m_axis_mm2s_tkeep`  out  BE_WIDTH  byte enables.
- `m_axis_mm2s_tvalid`  out  1  stream valid.
- `m_axis_mm2s_tlast`  out  1  last beat of the packet.
- `m_axis_mm2s_tready`  in  1  downstream ready.

## Operation
- **FSM states:** IDLE, SEND, DONE.
- **IDLE:**
  - `start`=1 with `pkt_len`≠0 and `pkt_count`≠0: latch `pkt_len`, `pkt_count` and `seed`, clear `tx_beats`, go to SEND.
  - `start`=1 with either value 0: go to DONE directly. No beats are sent and `tx_beats` is cleared.
- **Beats per packet:** `nbeats = ceil(pkt_len/BE_WIDTH)`, computed with 16-bit arithmetic (`pkt_len` ≤ 65535, so no overflow).
- **SEND:**
  - `tvalid`=1 for every cycle in SEND.
  - A beat is accepted when `tvalid && tready`.
  - On each accepted beat: `tdata` increments by 1 (modulo 2^AXI_DATA_WIDTH) and `tx_beats` increments by 1 (wraps at 2^32).
  - Beat counter runs 0..nbeats-1.
- **Data pattern:** the first beat of a run has `tdata` = `seed`. The pattern continues across packet boundaries; it is not reset per packet.
- **Framing:**
  - `tlast`=1 on beat nbeats-1.
  - `tkeep` = all ones on every beat except the last.
  - Last beat: `r = pkt_len mod BE_WIDTH`. `tkeep` = all ones if r=0, otherwise `(1<<r)-1`, i.e. the low bytes are valid.
- **Packet completion:** after an accepted `tlast` beat, the packet counter increments.
  - If the counter has reached `pkt_count`, or `abort` is 1 in that handshake cycle, go to DONE.
  - Otherwise start the next packet in the next cycle. There is no gap cycle.
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE.
- **Ignored inputs:**
  - `start` is ignored in SEND and DONE.
  - `abort` is ignored in IDLE.
  - `abort` never truncates a packet.
- **AXI rules:**
  - While `tvalid && !tready`, `tdata`, `tkeep` and `tlast` hold stable.
  - `tvalid` never drops without a handshake.
- **Reset:** asserting `axi_rst_n` low at any time forces IDLE and drives all outputs to 0, including `tvalid`. A packet in flight is dropped without `tlast`; the downstream FIFO must be reset together with this block.

## Timing
- All outputs are registered.
- Accepted `start` in cycle N: `busy` and `tvalid` are 1 from cycle N+1.
- With `tready` held at 1, a run lasts `pkt_count*nbeats` cycles of `tvalid`, followed by one DONE cycle with `done`=1 and `busy`=1.
- Back-to-back runs: the earliest next `start` is accepted in the cycle after DONE.
- `tready` may toggle every cycle. Throughput is 1 beat/cycle when `tready` is 1.
- A degenerate start (length or count 0) gives `done` in N+1 and IDLE in N+2.

## Test plan
- **Basic run:** `pkt_len`=20, `pkt_count`=2, `seed`=0x100, `tready`=1 -> six beats with `tdata` 0x100..0x105. `tlast` is set on beats 2 and 5, each with `tkeep`=0x0F; other beats have `tkeep`=0xFF. `done` fires one cycle after beat 5, and `tx_beats`=6.
- **Aligned length:** `pkt_len`=64, `pkt_count`=1 -> 8 beats, all with `tkeep`=0xFF, `tlast` on beat 7 only.
- **Backpressure:** random `tready` at 50% with `pkt_len`=100, `pkt_count`=3 -> 39 beats with no gaps or duplicates in `tdata`. Held data stays stable while `tready`=0, and the last beat of each packet has `tkeep`=0x0F.
- **Abort:** `pkt_count`=10, `pkt_len`=16; assert `abort` during packet 2 beat 0 -> packet 2 completes (2 beats, `tlast`), then `done`. `tx_beats`=6.
- **Degenerate and ignored start:** `pkt_len`=0 -> `done` in N+1, `tvalid` never rises. A `start` pulsed while `busy`=1 has no effect.
- **Reset mid-packet:** drop `axi_rst_n` during beat 1 -> `tvalid`, `busy`, `done` and `tx_beats` go to 0 immediately. A new `start` after release begins again at `seed`.

Source files
------------

// File: rtl/dma_loop_gen.sv
// AXI-Stream packet generator: emits pkt_count packets of pkt_len bytes with an
// incrementing data pattern starting at seed, tkeep on the final beat and tlast framing.
module dma_loop_gen #(
  parameter int AXI_DATA_WIDTH = 64
) (
  input  logic                        axi_clk,
  input  logic                        axi_rst_n,
  input  logic                        start,
  input  logic                        abort,
  input  logic [15:0]                 pkt_len,
  input  logic [15:0]                 pkt_count,
  input  logic [AXI_DATA_WIDTH-1:0]   seed,
  output logic                        busy,
  output logic                        done,
  output logic [31:0]                 tx_beats,
  output logic [AXI_DATA_WIDTH-1:0]   m_axis_mm2s_tdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axis_mm2s_tkeep,
  output logic                        m_axis_mm2s_tvalid,
  output logic                        m_axis_mm2s_tlast,
  input  logic                        m_axis_mm2s_tready
);

  localparam int BE_WIDTH = AXI_DATA_WIDTH / 8;
  localparam int LG       = $clog2(BE_WIDTH);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             len_q, len_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [15:0]             beat_q, beat_d;
  logic [15:0]             pkt_q, pkt_d;
  logic [15:0]             nbeats_d;
  logic [15:0]             pkt_nxt;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]             txb_q, txb_d;
  logic [BE_WIDTH-1:0]     keep_q, keep_d;
  logic [BE_WIDTH-1:0]     one;
  logic [LG-1:0]           rem;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    accept;

  assign accept  = valid_q & m_axis_mm2s_tready;
  assign pkt_nxt = pkt_q + 16'd1;
  assign one     = BE_WIDTH'(1);

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      pkt_q   <= '0;
      data_q  <= '0;
      txb_q   <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      data_q  <= data_d;
      txb_q   <= txb_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (pkt_len != '0 && pkt_count != '0) ? SEND : DONE;
      SEND: if (accept && last_q && (pkt_nxt == cnt_q || abort)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so framing for the next beat is derived from the
  // next-state counters rather than the current ones.
  always_comb begin
    len_d  = len_q;
    cnt_d  = cnt_q;
    beat_d = beat_q;
    pkt_d  = pkt_q;
    data_d = data_q;
    txb_d  = txb_q;
    if (state_q == IDLE && start) begin
      txb_d = '0;
      if (state_d == SEND) begin
        len_d  = pkt_len;
        cnt_d  = pkt_count;
        data_d = seed;
        beat_d = '0;
        pkt_d  = '0;
      end
    end else if (state_q == SEND && accept) begin
      data_d = data_q + 1'b1;
      txb_d  = txb_q + 32'd1;
      if (last_q) begin
        beat_d = '0;
        pkt_d  = pkt_nxt;
      end else begin
        beat_d = beat_q + 16'd1;
      end
    end

    nbeats_d = (len_d >> LG) + {15'b0, |len_d[LG-1:0]};
    rem      = len_d[LG-1:0];
    valid_d  = (state_d == SEND);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    last_d   = valid_d && (beat_d == nbeats_d - 16'd1);
    if (!valid_d)                keep_d = '0;
    else if (last_d && rem != '0) keep_d = (one << rem) - one;
    else                         keep_d = '1;
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign tx_beats           = txb_q;
  assign m_axis_mm2s_tdata  = data_q;
  assign m_axis_mm2s_tkeep  = keep_q;
  assign m_axis_mm2s_tvalid = valid_q;
  assign m_axis_mm2s_tlast  = last_q;

endmodule

// File: tb/tb_dma_loop_gen.sv
// Directed bench for dma_loop_gen: expected beats are queued at each start and
// checked by a stream monitor; run latency and counters checked in-line.
module tb_dma_loop_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] pkt_len = '0;
  logic [15:0] pkt_count = '0;
  logic [63:0] seed = '0;
  logic        busy, done;
  logic [31:0] tx_beats;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid, tlast;
  logic        tready = 1'b1;
  logic        rand_rdy = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;
  beat_t exp_q[$];

  dma_loop_gen #(.AXI_DATA_WIDTH(64)) dut (
    .axi_clk(clk), .axi_rst_n(rst_n), .start(start), .abort(abort),
    .pkt_len(pkt_len), .pkt_count(pkt_count), .seed(seed),
    .busy(busy), .done(done), .tx_beats(tx_beats),
    .m_axis_mm2s_tdata(tdata), .m_axis_mm2s_tkeep(tkeep),
    .m_axis_mm2s_tvalid(tvalid), .m_axis_mm2s_tlast(tlast),
    .m_axis_mm2s_tready(tready)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_run(input int len, input int npk, input logic [63:0] s);
    int nb;
    int r;
    logic [63:0] d;
    beat_t b;
    nb = (len + 7) / 8;
    r  = len % 8;
    d  = s;
    for (int p = 0; p < npk; p++) begin
      for (int i = 0; i < nb; i++) begin
        b.d = d;
        b.l = (i == nb - 1);
        b.k = (b.l && r != 0) ? 8'((16'd1 << r) - 16'd1) : 8'hFF;
        exp_q.push_back(b);
        d = d + 64'd1;
      end
    end
  endtask

  task automatic pulse(input logic [15:0] len, input logic [15:0] cnt, input logic [63:0] s);
    pkt_len = len;
    pkt_count = cnt;
    seed = s;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit, input int exp_n, input int exp_beats);
    int n;
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (n == 1) chk({tag, "_busy_first"}, 64'(busy), 64'd1);
      if (done) break;
    end
    chk({tag, "_done_latency"}, 64'(n), 64'(exp_n));
    chk({tag, "_busy_in_done"}, 64'(busy), 64'd1);
    chk({tag, "_tx_beats"}, 64'(tx_beats), 64'(exp_beats));
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    chk({tag, "_idle_valid"}, 64'(tvalid), 64'd0);
  endtask

  logic        stall = 1'b0;
  logic [63:0] hd;
  logic [7:0]  hk;
  logic        hl;
  beat_t       got;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("hold_valid", 64'(tvalid), 64'd1);
        chk("hold_data", tdata, hd);
        chk("hold_keep", 64'(tkeep), 64'(hk));
        chk("hold_last", 64'(tlast), 64'(hl));
      end
      if (tvalid && tready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_beat", 64'(exp_q.size()), 64'd1);
        end else begin
          got = exp_q.pop_front();
          chk("beat_data", tdata, got.d);
          chk("beat_keep", 64'(tkeep), 64'(got.k));
          chk("beat_last", 64'(tlast), 64'(got.l));
        end
      end
      stall = tvalid && !tready;
      hd = tdata;
      hk = tkeep;
      hl = tlast;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_valid", 64'(tvalid), 64'd0);
    chk("rst_tx_beats", 64'(tx_beats), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic: 20 bytes x 2 packets
    push_run(20, 2, 64'h100);
    pulse(16'd20, 16'd2, 64'h100);
    wait_done("basic", 50, 7, 6);

    // aligned length, data wraps past all-ones
    push_run(64, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    pulse(16'd64, 16'd1, 64'hFFFF_FFFF_FFFF_FFFC);
    wait_done("aligned", 50, 9, 8);

    // random backpressure
    rand_rdy = 1'b1;
    push_run(100, 3, 64'h0123_4567_89AB_0000);
    pulse(16'd100, 16'd3, 64'h0123_4567_89AB_0000);
    begin : bp_wait
      int n;
      n = 0;
      while (!done && n < 1000) begin
        @(negedge clk);
        n++;
      end
      chk("bp_done_seen", 64'(done), 64'd1);
      chk("bp_tx_beats", 64'(tx_beats), 64'd39);
      chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);
    end
    rand_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("bp_idle_busy", 64'(busy), 64'd0);

    // abort during packet 2 beat 0
    push_run(16, 3, 64'hA000);
    pulse(16'd16, 16'd10, 64'hA000);
    repeat (4) @(posedge clk);
    #1;
    abort = 1'b1;
    wait_done("abort", 50, 3, 6);
    abort = 1'b0;

    // degenerate starts
    pulse(16'd0, 16'd5, 64'h55);
    wait_done("degen_len", 10, 1, 0);
    pulse(16'd8, 16'd0, 64'h55);
    wait_done("degen_cnt", 10, 1, 0);

    // start while busy is ignored
    push_run(32, 1, 64'hB000);
    pulse(16'd32, 16'd1, 64'hB000);
    pkt_len = 16'd8;
    pkt_count = 16'd7;
    seed = 64'hDEAD;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ign_start", 20, 4, 4);

    // reset mid-packet
    push_run(40, 1, 64'hC000);
    pulse(16'd40, 16'd1, 64'hC000);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(tvalid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_done", 64'(done), 64'd0);
    chk("mrst_tx_beats", 64'(tx_beats), 64'd0);
    exp_q.delete();
    #10;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_idle_valid", 64'(tvalid), 64'd0);
    push_run(8, 1, 64'hC000);
    pulse(16'd8, 16'd1, 64'hC000);
    wait_done("post_rst", 20, 2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
